// File: rtl/ah_demux_pkg.sv
// ----------------------------------------------------------------------------
// ah_demux_pkg
// Shared definitions for the packet-aware demultiplexer (ah_demux_pkt) and
// its skid buffer.
//   - sel_width(): select width needed to address N egress channels
//   - fsm_state_t: ingress packet-lock FSM states (IDLE / LOCKED)
// The beat-tag struct {data, last, ch, drop} depends on module parameters
// (DATA_W, SEL_W), so it is declared inside ah_demux_pkt from its localparams.
// No ports (package).
// ----------------------------------------------------------------------------
package ah_demux_pkg;

  // Ingress FSM: IDLE waits for a packet's first beat, LOCKED holds the
  // channel chosen on that beat until the last beat is accepted.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fsm_state_t;

  // ceil(log2(n)), never less than 1 so a select port always exists.
  function automatic int sel_width(input int n);
    for (int w = 1; w < 31; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/ah_skid_buf2.sv
// ----------------------------------------------------------------------------
// ah_skid_buf2
// Generic 2-entry valid/ready FIFO buffer. in_ready comes straight from a
// flop, so the upstream handshake never depends combinationally on out_ready.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_data/valid/ready upstream side; in_ready = registered "not full",
//                       held low during reset
//   out_data/valid/ready downstream side; out_data is the FIFO head
// ----------------------------------------------------------------------------
module ah_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic         push;
  logic         pop;

  assign push      = in_valid && in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // With one entry stored the free slot is the other one; with zero it is
  // the read slot itself. A push never happens at count==2 (in_ready low).
  assign wr_ptr    = rd_ptr ^ count[0];
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};

  // in_ready is computed from the next occupancy so it is valid the cycle
  // after any push/pop; being reset to 0 keeps the input closed in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
      if (pop)  rd_ptr      <= ~rd_ptr;
      if (push) mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/ah_demux_pkt.sv
// ----------------------------------------------------------------------------
// ah_demux_pkt
// Packet-aware valid/ready demultiplexer: one ingress stream is routed to one
// of N_EGR egress streams. The channel is chosen on a packet's first beat and
// held until its last beat, so packets never interleave across channels. A
// 2-entry skid buffer registers the datapath; ing_ready is a flop output.
// Beats whose channel index is >= N_EGR are dropped without any egr_valid.
//
// Parameters: N_EGR (>=2), DATA_W, SEL_W (default sel_width(N_EGR)).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   select                egress index, sampled on a packet's first beat
//   ing_data/last/valid   ingress beat
//   ing_ready             ingress ready (registered)
//   egr_data              N_EGR x DATA_W, every channel carries the head data
//   egr_last/valid        per-channel last / valid (at most one valid high)
//   egr_ready             per-channel ready (only the head's channel matters)
// Optional (macro AH_DEMUX_PKT_ERR_EN):
//   err_oor               sticky, set when a dropped beat leaves the buffer
//   drop_cnt              saturating count of dropped packets (drop beats
//                         carrying last)
// ----------------------------------------------------------------------------
module ah_demux_pkt
  import ah_demux_pkg::*;
#(
  parameter int N_EGR  = 18,
  parameter int DATA_W = 9,
  parameter int SEL_W  = sel_width(N_EGR)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        select,
  input  logic [DATA_W-1:0]       ing_data,
  input  logic                    ing_last,
  input  logic                    ing_valid,
  output logic                    ing_ready,
  output logic [N_EGR*DATA_W-1:0] egr_data,
  output logic [N_EGR-1:0]        egr_last,
  output logic [N_EGR-1:0]        egr_valid,
  input  logic [N_EGR-1:0]        egr_ready
`ifdef AH_DEMUX_PKT_ERR_EN
  ,
  output logic                    err_oor,
  output logic [15:0]             drop_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [SEL_W-1:0]  ch;
    logic              drop;
  } beat_t;

  localparam int TAG_W = $bits(beat_t);

  fsm_state_t       state;
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] eff_sel;
  logic             accept;
  beat_t            in_tag;
  beat_t            head;
  logic [TAG_W-1:0] head_bits;
  logic             head_valid;
  logic             head_ready;

  assign accept  = ing_valid && ing_ready;
  assign eff_sel = (state == LOCKED) ? cur_sel : select;

  // Packet lock FSM. In LOCKED eff_sel equals cur_sel, so latching eff_sel
  // on every accepted beat only changes cur_sel on a first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_sel <= '0;
    end else if (accept) begin
      cur_sel <= eff_sel;
      state   <= ing_last ? IDLE : LOCKED;
    end
  end

  // Widen by one bit so the range check also works when N_EGR == 2**SEL_W.
  always_comb begin
    in_tag.data = ing_data;
    in_tag.last = ing_last;
    in_tag.ch   = eff_sel;
    in_tag.drop = ({1'b0, eff_sel} >= (SEL_W+1)'(N_EGR));
  end

  ah_skid_buf2 #(
    .W (TAG_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_tag),
    .in_valid  (ing_valid),
    .in_ready  (ing_ready),
    .out_data  (head_bits),
    .out_valid (head_valid),
    .out_ready (head_ready)
  );

  assign head = beat_t'(head_bits);

  // Egress steering. A drop head pops immediately with no valid; otherwise
  // only the head's channel sees valid and only its ready pops the head.
  // Outputs are forced to 0 while the buffer is empty.
  always_comb begin
    egr_valid  = '0;
    egr_last   = '0;
    egr_data   = '0;
    head_ready = 1'b0;
    if (head_valid) begin
      if (head.drop) begin
        head_ready = 1'b1;
      end else begin
        for (int k = 0; k < N_EGR; k++) begin
          if (head.ch == SEL_W'(k)) begin
            egr_valid[k] = 1'b1;
            head_ready   = egr_ready[k];
          end
        end
      end
      for (int k = 0; k < N_EGR; k++) begin
        egr_data[k*DATA_W +: DATA_W] = head.data;
        egr_last[k]                  = head.last;
      end
    end
  end

`ifdef AH_DEMUX_PKT_ERR_EN
  logic drop_pop;

  assign drop_pop = head_valid && head.drop;

  // Error reporting: sticky out-of-range flag and saturating dropped-packet
  // counter, both cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_oor  <= 1'b0;
      drop_cnt <= 16'h0000;
    end else begin
      if (drop_pop) err_oor <= 1'b1;
      if (drop_pop && head.last && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ah_demux_pkt.sv
// ----------------------------------------------------------------------------
// tb_ah_demux_pkt
// Directed self-checking bench for ah_demux_pkt (default parameters:
// N_EGR=18, DATA_W=9, SEL_W=5). Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point, after the edge has settled.
// Optional checks for macro AH_DEMUX_PKT_ERR_EN.
// ----------------------------------------------------------------------------
module tb_ah_demux_pkt;

  localparam int N_EGR  = 18;
  localparam int DATA_W = 9;
  localparam int SEL_W  = 5;

  logic                    clk;
  logic                    rst_n;
  logic [SEL_W-1:0]        select;
  logic [DATA_W-1:0]       ing_data;
  logic                    ing_last;
  logic                    ing_valid;
  logic                    ing_ready;
  logic [N_EGR*DATA_W-1:0] egr_data;
  logic [N_EGR-1:0]        egr_last;
  logic [N_EGR-1:0]        egr_valid;
  logic [N_EGR-1:0]        egr_ready;
`ifdef AH_DEMUX_PKT_ERR_EN
  logic                    err_oor;
  logic [15:0]             drop_cnt;
`endif

  int tests_run = 0;
  int fails     = 0;

  ah_demux_pkt #(
    .N_EGR  (N_EGR),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .select    (select),
    .ing_data  (ing_data),
    .ing_last  (ing_last),
    .ing_valid (ing_valid),
    .ing_ready (ing_ready),
    .egr_data  (egr_data),
    .egr_last  (egr_last),
    .egr_valid (egr_valid),
    .egr_ready (egr_ready)
`ifdef AH_DEMUX_PKT_ERR_EN
    ,
    .err_oor   (err_oor),
    .drop_cnt  (drop_cnt)
`endif
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] sel,
                               input logic [DATA_W-1:0] d, input logic l);
    ing_valid = v;
    select    = sel;
    ing_data  = d;
    ing_last  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] ch_data(input int k);
    return egr_data[k*DATA_W +: DATA_W];
  endfunction

  initial begin
    rst_n     = 1'b0;
    egr_ready = '1;
    applyStimulus(1'b0, 5'd0, 9'h000, 1'b0);

    // Reset held for 3 cycles
    tick(); tick(); tick();
    checkOutput("rst_ready_low", 32'(ing_ready), 32'd0);
    checkOutput("rst_valid_low", 32'(egr_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_ready_after", 32'(ing_ready), 32'd1);
    checkOutput("rst_valid_after", 32'(egr_valid), 32'd0);
    checkOutput("rst_data_after", 32'(ch_data(0)), 32'd0);
    checkOutput("rst_last_after", 32'(egr_last), 32'd0);

    // Packet lock: select 5 on the first beat, 2 on the rest
    applyStimulus(1'b1, 5'd5, 9'h101, 1'b0);
    tick();
    checkOutput("lock_v0", 32'(egr_valid), 32'h0000_0020);
    checkOutput("lock_d0", 32'(ch_data(5)), 32'h101);
    applyStimulus(1'b1, 5'd2, 9'h102, 1'b0);
    tick();
    checkOutput("lock_v1", 32'(egr_valid), 32'h0000_0020);
    checkOutput("lock_d1", 32'(ch_data(5)), 32'h102);
    applyStimulus(1'b1, 5'd2, 9'h103, 1'b0);
    tick();
    checkOutput("lock_v2", 32'(egr_valid), 32'h0000_0020);
    checkOutput("lock_d2", 32'(ch_data(5)), 32'h103);
    checkOutput("lock_l2", 32'(egr_last[5]), 32'd0);
    applyStimulus(1'b1, 5'd2, 9'h104, 1'b1);
    tick();
    checkOutput("lock_v3", 32'(egr_valid), 32'h0000_0020);
    checkOutput("lock_d3", 32'(ch_data(5)), 32'h104);
    checkOutput("lock_l3", 32'(egr_last[5]), 32'd1);
    applyStimulus(1'b0, 5'd0, 9'h000, 1'b0);
    tick();
    checkOutput("lock_idle", 32'(egr_valid), 32'd0);

    // Back-to-back single-beat packets to 0, 17, 3
    applyStimulus(1'b1, 5'd0, 9'h0AA, 1'b1);
    tick();
    checkOutput("b2b_v0", 32'(egr_valid), 32'h0000_0001);
    checkOutput("b2b_d0", 32'(ch_data(0)), 32'h0AA);
    applyStimulus(1'b1, 5'd17, 9'h1BB, 1'b1);
    tick();
    checkOutput("b2b_v17", 32'(egr_valid), 32'h0002_0000);
    checkOutput("b2b_d17", 32'(ch_data(17)), 32'h1BB);
    applyStimulus(1'b1, 5'd3, 9'h033, 1'b1);
    tick();
    checkOutput("b2b_v3", 32'(egr_valid), 32'h0000_0008);
    checkOutput("b2b_d3", 32'(ch_data(3)), 32'h033);
    checkOutput("b2b_ready", 32'(ing_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 9'h000, 1'b0);
    tick();
    checkOutput("b2b_idle", 32'(egr_valid), 32'd0);

    // Backpressure: channel 7 stalled for 5 cycles, channel 6 ready
    egr_ready    = '1;
    egr_ready[7] = 1'b0;
    applyStimulus(1'b1, 5'd7, 9'h070, 1'b0);
    tick();
    checkOutput("bp_v_a", 32'(egr_valid), 32'h0000_0080);
    checkOutput("bp_d_a", 32'(ch_data(7)), 32'h070);
    checkOutput("bp_rdy_a", 32'(ing_ready), 32'd1);
    applyStimulus(1'b1, 5'd7, 9'h071, 1'b0);
    tick();
    checkOutput("bp_rdy_b", 32'(ing_ready), 32'd0);
    checkOutput("bp_d_b", 32'(ch_data(7)), 32'h070);
    applyStimulus(1'b1, 5'd7, 9'h072, 1'b0);
    tick();
    checkOutput("bp_rdy_c", 32'(ing_ready), 32'd0);
    tick();
    tick();
    checkOutput("bp_rdy_e", 32'(ing_ready), 32'd0);
    checkOutput("bp_v_e", 32'(egr_valid), 32'h0000_0080);
    checkOutput("bp_d_e", 32'(ch_data(7)), 32'h070);
    egr_ready[7] = 1'b1;
    tick();
    checkOutput("bp_d_f", 32'(ch_data(7)), 32'h071);
    checkOutput("bp_rdy_f", 32'(ing_ready), 32'd1);
    tick();
    checkOutput("bp_d_g", 32'(ch_data(7)), 32'h072);
    applyStimulus(1'b1, 5'd7, 9'h073, 1'b1);
    tick();
    checkOutput("bp_d_h", 32'(ch_data(7)), 32'h073);
    checkOutput("bp_l_h", 32'(egr_last[7]), 32'd1);
    checkOutput("bp_v_h", 32'(egr_valid), 32'h0000_0080);
    applyStimulus(1'b0, 5'd0, 9'h000, 1'b0);
    tick();
    checkOutput("bp_idle", 32'(egr_valid), 32'd0);

    // Out-of-range 3-beat packet (select 20) is dropped
    applyStimulus(1'b1, 5'd20, 9'h1E0, 1'b0);
    tick();
    checkOutput("oor_v0", 32'(egr_valid), 32'd0);
    checkOutput("oor_r0", 32'(ing_ready), 32'd1);
    applyStimulus(1'b1, 5'd20, 9'h1E1, 1'b0);
    tick();
    checkOutput("oor_v1", 32'(egr_valid), 32'd0);
    checkOutput("oor_r1", 32'(ing_ready), 32'd1);
    applyStimulus(1'b1, 5'd20, 9'h1E2, 1'b1);
    tick();
    checkOutput("oor_v2", 32'(egr_valid), 32'd0);
    checkOutput("oor_r2", 32'(ing_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 9'h000, 1'b0);
    tick();
    checkOutput("oor_idle", 32'(egr_valid), 32'd0);
`ifdef AH_DEMUX_PKT_ERR_EN
    checkOutput("oor_err", 32'(err_oor), 32'd1);
    checkOutput("oor_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Reset in the middle of a packet to channel 4 (stalled, 2 beats held)
    egr_ready[4] = 1'b0;
    applyStimulus(1'b1, 5'd4, 9'h040, 1'b0);
    tick();
    checkOutput("mid_v0", 32'(egr_valid), 32'h0000_0010);
    checkOutput("mid_d0", 32'(ch_data(4)), 32'h040);
    applyStimulus(1'b1, 5'd4, 9'h041, 1'b0);
    tick();
    checkOutput("mid_rdy_full", 32'(ing_ready), 32'd0);
    applyStimulus(1'b0, 5'd0, 9'h000, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_v", 32'(egr_valid), 32'd0);
    checkOutput("mid_rst_r", 32'(ing_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_after_r", 32'(ing_ready), 32'd1);
    checkOutput("mid_after_v", 32'(egr_valid), 32'd0);
`ifdef AH_DEMUX_PKT_ERR_EN
    checkOutput("mid_err_clr", 32'(err_oor), 32'd0);
    checkOutput("mid_cnt_clr", 32'(drop_cnt), 32'd0);
`endif
    egr_ready = '1;
    applyStimulus(1'b1, 5'd9, 9'h090, 1'b1);
    tick();
    checkOutput("mid_new_v", 32'(egr_valid), 32'h0000_0200);
    checkOutput("mid_new_d", 32'(ch_data(9)), 32'h090);
    checkOutput("mid_new_l", 32'(egr_last[9]), 32'd1);
    applyStimulus(1'b0, 5'd0, 9'h000, 1'b0);
    tick();
    checkOutput("mid_idle", 32'(egr_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
